// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: host-side command scheduler for the behavioural DRAM model.
// After reset it writes RL/WL into MR0/MR1 and reads them back. It then
// arbitrates two requesters round-robin and turns each accepted request into
// a timed W (with data-land strobe) or R (with capture and timeout).
// The state register names the phase the DRAM pins are showing right now;
// each transition registers the pin values for the phase being entered.
module dram_cmd_sched #(
    parameter int RL         = 8,
    parameter int WL         = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_VALID,
    input  logic       REQ0_WR,
    input  logic [7:0] REQ0_ADDR,
    input  logic [7:0] REQ0_WDATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic       REQ1_WR,
    input  logic [7:0] REQ1_ADDR,
    input  logic [7:0] REQ1_WDATA,
    output logic       REQ1_READY,
    output logic       RSP_VALID,
    output logic       RSP_ID,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_ERR,
    output logic       INIT_DONE,
    output logic       INIT_ERR,
    output logic       DRAM_R,
    output logic       DRAM_W,
    output logic       DRAM_MRW,
    output logic       DRAM_MRR,
    output logic       DRAM_DRIV_VALID,
    output logic [7:0] DRAM_ADDR,
    output logic [7:0] DRAM_DQ_IN,
    input  logic [7:0] DRAM_DQ_OUT,
    input  logic       DRAM_DQ_OE
);

    localparam logic [7:0] RL8    = 8'(RL);
    localparam logic [7:0] WL8    = 8'(WL);
    localparam logic [8:0] WL9    = 9'(WL);
    // Last RD_WAIT count value before the read is declared lost.
    localparam logic [8:0] RD_LIM = 9'(RL + 1 + RD_TIMEOUT);

    // ST_RESET is only occupied while reset is held; its exit issues the MR0 write.
    typedef enum logic [3:0] {
        ST_RESET,
        ST_INIT_MR0,
        ST_INIT_MR1,
        ST_CHK_MR0,
        ST_CHK_MR1,
        ST_CHK_END,
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_WAIT,
        ST_WR_DRV,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_ERR
    } state_t;

    state_t     state_r;
    logic       last_gnt_r;
    logic [8:0] cnt_r;
    logic       mr0_ok_r;
    logic       cap_id_r;
    logic [7:0] cap_addr_r;
    logic [7:0] cap_wdata_r;

    logic       rsp_valid_r;
    logic       rsp_id_r;
    logic [7:0] rsp_rdata_r;
    logic       rsp_err_r;
    logic       init_done_r;
    logic       init_err_r;
    logic       r_r;
    logic       w_r;
    logic       mrw_r;
    logic       mrr_r;
    logic       driv_r;
    logic [7:0] addr_r;
    logic [7:0] dq_in_r;

    logic       gnt0_s;
    logic       gnt1_s;
    logic       sel_wr_s;
    logic [7:0] sel_addr_s;
    logic [7:0] sel_wdata_s;

    // Round-robin grant in IDLE: a lone requester wins, on contention the port not granted last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            gnt0_s = REQ0_VALID & (~REQ1_VALID | last_gnt_r);
            gnt1_s = REQ1_VALID & (~REQ0_VALID | ~last_gnt_r);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Request fields of the current winner, captured on the handshake.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = 8'h00;
        sel_wdata_s = 8'h00;
        if (gnt1_s) begin
            sel_wr_s    = REQ1_WR;
            sel_addr_s  = REQ1_ADDR;
            sel_wdata_s = REQ1_WDATA;
        end else begin
            sel_wr_s    = REQ0_WR;
            sel_addr_s  = REQ0_ADDR;
            sel_wdata_s = REQ0_WDATA;
        end
    end

    // Main sequencer: init programming/readback, command issue, latency counting, responses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_RESET;
            last_gnt_r  <= 1'b1;
            cnt_r       <= 9'd0;
            mr0_ok_r    <= 1'b0;
            cap_id_r    <= 1'b0;
            cap_addr_r  <= 8'h00;
            cap_wdata_r <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
            init_done_r <= 1'b0;
            init_err_r  <= 1'b0;
            r_r         <= 1'b0;
            w_r         <= 1'b0;
            mrw_r       <= 1'b0;
            mrr_r       <= 1'b0;
            driv_r      <= 1'b0;
            addr_r      <= 8'h00;
            dq_in_r     <= 8'h00;
        end else begin
            // Strobes and response fields are single-cycle unless a state below sets them.
            r_r         <= 1'b0;
            w_r         <= 1'b0;
            mrw_r       <= 1'b0;
            mrr_r       <= 1'b0;
            driv_r      <= 1'b0;
            addr_r      <= 8'h00;
            dq_in_r     <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
            case (state_r)
                ST_RESET: begin
                    mrw_r   <= 1'b1;
                    addr_r  <= 8'h00;
                    dq_in_r <= RL8;
                    state_r <= ST_INIT_MR0;
                end
                ST_INIT_MR0: begin
                    mrw_r   <= 1'b1;
                    addr_r  <= 8'h01;
                    dq_in_r <= WL8;
                    state_r <= ST_INIT_MR1;
                end
                ST_INIT_MR1: begin
                    mrr_r   <= 1'b1;
                    addr_r  <= 8'h00;
                    state_r <= ST_CHK_MR0;
                end
                ST_CHK_MR0: begin
                    mrr_r   <= 1'b1;
                    addr_r  <= 8'h01;
                    state_r <= ST_CHK_MR1;
                end
                ST_CHK_MR1: begin
                    // MR0 readback is on the bus during this phase.
                    mr0_ok_r <= (DRAM_DQ_OUT == RL8);
                    state_r  <= ST_CHK_END;
                end
                ST_CHK_END: begin
                    if (mr0_ok_r && (DRAM_DQ_OUT == WL8)) begin
                        init_done_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        init_err_r  <= 1'b1;
                        state_r     <= ST_ERR;
                    end
                end
                ST_IDLE: begin
                    if (gnt0_s || gnt1_s) begin
                        cap_id_r    <= gnt1_s;
                        cap_addr_r  <= sel_addr_s;
                        cap_wdata_r <= sel_wdata_s;
                        last_gnt_r  <= gnt1_s;
                        addr_r      <= sel_addr_s;
                        if (sel_wr_s) begin
                            w_r     <= 1'b1;
                            dq_in_r <= sel_wdata_s;
                            state_r <= ST_WR_CMD;
                        end else begin
                            r_r     <= 1'b1;
                            state_r <= ST_RD_CMD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_CMD: begin
                    addr_r <= cap_addr_r;
                    if (WL9 == 9'd0) begin
                        driv_r  <= 1'b1;
                        dq_in_r <= cap_wdata_r;
                        state_r <= ST_WR_DRV;
                    end else begin
                        cnt_r   <= 9'd1;
                        state_r <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    addr_r <= cap_addr_r;
                    if (cnt_r == WL9) begin
                        driv_r  <= 1'b1;
                        dq_in_r <= cap_wdata_r;
                        state_r <= ST_WR_DRV;
                    end else begin
                        cnt_r   <= cnt_r + 9'd1;
                    end
                end
                ST_WR_DRV: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= cap_id_r;
                    state_r     <= ST_IDLE;
                end
                ST_RD_CMD: begin
                    cnt_r   <= 9'd0;
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (DRAM_DQ_OE) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= cap_id_r;
                        rsp_rdata_r <= DRAM_DQ_OUT;
                        state_r     <= ST_IDLE;
                    end else if (cnt_r == RD_LIM) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= cap_id_r;
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r       <= cnt_r + 9'd1;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    // Unreachable encoding: park safely with the error flag raised.
                    init_done_r <= 1'b0;
                    init_err_r  <= 1'b1;
                    state_r     <= ST_ERR;
                end
            endcase
        end
    end

    assign REQ0_READY      = gnt0_s;
    assign REQ1_READY      = gnt1_s;
    assign RSP_VALID       = rsp_valid_r;
    assign RSP_ID          = rsp_id_r;
    assign RSP_RDATA       = rsp_rdata_r;
    assign RSP_ERR         = rsp_err_r;
    assign INIT_DONE       = init_done_r;
    assign INIT_ERR        = init_err_r;
    assign DRAM_R          = r_r;
    assign DRAM_W          = w_r;
    assign DRAM_MRW        = mrw_r;
    assign DRAM_MRR        = mrr_r;
    assign DRAM_DRIV_VALID = driv_r;
    assign DRAM_ADDR       = addr_r;
    assign DRAM_DQ_IN      = dq_in_r;

endmodule
